d_sram_like_bridge: RTL and testbench

- Data-side bridge between the pipeline memory stage and a sram-like data bus.
- Takes the M-stage access (address from aluoutM, store data from writedataM, byte strobes from sig_write). Issues one bus transaction per access.
- Returns load data as readdataM and raises a stall request until the access completes.
- Holds returned load data while other stall sources keep the pipeline frozen.

---
 rtl/d_sram_like_bridge_pkg.sv | 18 +
 rtl/d_sram_like_bridge.sv | 170 +++++++++++++++++
 tb/tb_d_sram_like_bridge.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/d_sram_like_bridge_pkg.sv
// d_sram_like_bridge_pkg
//   Shared definitions for the sram-like bus bridges (data and instruction side).
//   - bridge_state_e : 2-bit bridge FSM encoding
//   - SZ_*           : bus size codes carried on data_size / mem_size
package d_sram_like_bridge_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitAddr = 2'd1,
        StWaitData = 2'd2,
        StHold     = 2'd3
    } bridge_state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/d_sram_like_bridge.sv
// d_sram_like_bridge
//   Data-side bridge between the pipeline M stage and a sram-like data bus.
//   One bus transaction per M-stage access, at most one outstanding. Load data is
//   returned on mem_rdata and held while other stall sources freeze the pipeline.
//
// Ports
//   clk, rst        : clock, asynchronous active-low reset
//   mem_req         : M stage holds a load/store (level, held while stalled)
//   mem_wr          : 1 = store, 0 = load
//   mem_size        : 0 byte, 1 half, 2 word
//   mem_wstrb       : byte enables
//   mem_addr        : byte address
//   mem_wdata       : lane-aligned store data
//   longest_stall   : OR of all pipeline stall sources (includes d_stall)
//   mem_rdata       : load data to the pipeline
//   d_stall         : data-access stall request
//   data_*          : sram-like bus master side
module d_sram_like_bridge
    import d_sram_like_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                mem_req,
    input  logic                mem_wr,
    input  logic [1:0]          mem_size,
    input  logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic                longest_stall,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                d_stall,

    output logic                data_req,
    output logic                data_wr,
    output logic [1:0]          data_size,
    output logic [DATA_W/8-1:0] data_wstrb,
    output logic [ADDR_W-1:0]   data_addr,
    output logic [DATA_W-1:0]   data_wdata,
    input  logic                data_addr_ok,
    input  logic                data_data_ok,
    input  logic [DATA_W-1:0]   data_rdata
);

    localparam int unsigned StrbW = DATA_W / 8;

    bridge_state_e     state_q, state_d;

    // Latched command, replayed on the bus while waiting for addr_ok.
    logic              cmd_wr_q;
    logic [1:0]        cmd_size_q;
    logic [StrbW-1:0]  cmd_wstrb_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [DATA_W-1:0] cmd_wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic              cmd_ld;
    logic              rdata_ld;
    logic              st_idle, st_wait_addr, st_wait_data;
    logic [StrbW-1:0]  mem_wstrb_eff;

    assign st_idle      = (state_q == StIdle);
    assign st_wait_addr = (state_q == StWaitAddr);
    assign st_wait_data = (state_q == StWaitData);

    // Loads never drive strobes onto the bus.
    assign mem_wstrb_eff = mem_wr ? mem_wstrb : '0;

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d  = state_q;
        cmd_ld   = 1'b0;
        rdata_ld = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_req) begin
                    cmd_ld  = 1'b1;
                    state_d = data_addr_ok ? StWaitData : StWaitAddr;
                end
            end
            StWaitAddr: begin
                if (data_addr_ok) begin
                    state_d = StWaitData;
                end
            end
            StWaitData: begin
                // d_stall is already low in the data_ok cycle, so a high
                // longest_stall here comes from some other stall source.
                if (data_data_ok) begin
                    rdata_ld = 1'b1;
                    state_d  = longest_stall ? StHold : StIdle;
                end
            end
            StHold: begin
                if (!longest_stall) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cmd_wr_q    <= 1'b0;
            cmd_size_q  <= 2'b00;
            cmd_wstrb_q <= '0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q <= state_d;
            if (cmd_ld) begin
                cmd_wr_q    <= mem_wr;
                cmd_size_q  <= mem_size;
                cmd_wstrb_q <= mem_wstrb_eff;
                cmd_addr_q  <= mem_addr;
                cmd_wdata_q <= mem_wdata;
            end
            if (rdata_ld) begin
                rdata_q <= data_rdata;
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    // IDLE issues straight from the M stage (zero-latency); WAIT_ADDR replays
    // the latched command so M-stage changes cannot corrupt a pending request.
    // Every output is also forced low while rst is asserted.
    always_comb begin
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_size  = 2'b00;
        data_wstrb = '0;
        data_addr  = '0;
        data_wdata = '0;
        d_stall    = 1'b0;
        mem_rdata  = rdata_q;
        if (rst) begin
            if (st_idle) begin
                data_req   = mem_req;
                data_wr    = mem_wr;
                data_size  = mem_size;
                data_wstrb = mem_wstrb_eff;
                data_addr  = mem_addr;
                data_wdata = mem_wdata;
            end else begin
                data_req   = st_wait_addr;
                data_wr    = cmd_wr_q;
                data_size  = cmd_size_q;
                data_wstrb = cmd_wstrb_q;
                data_addr  = cmd_addr_q;
                data_wdata = cmd_wdata_q;
            end
            d_stall = mem_req &
                      (st_idle | st_wait_addr | (st_wait_data & ~data_data_ok));
            // Forward bus data in the completion cycle so the pipeline can
            // advance without an extra cycle.
            if (st_wait_data && data_data_ok) begin
                mem_rdata = data_rdata;
            end
        end
    end

endmodule

// File: tb/tb_d_sram_like_bridge.sv
module tb_d_sram_like_bridge;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        longest_stall;
    logic [31:0] mem_rdata;
    logic        d_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int total;
    int bad;

    d_sram_like_bridge #(
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .longest_stall(longest_stall),
        .mem_rdata    (mem_rdata),
        .d_stall      (d_stall),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per clock cycle: inputs applied, outputs expected in that cycle.
    typedef struct {
        int          scen;
        logic        req;
        logic        wr;
        logic [1:0]  sz;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ls;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        e_stall;
        logic        e_req;
        logic [31:0] e_rdata;
        logic        bus;       // compare bus fields too
        logic        e_wr;
        logic [1:0]  e_sz;
        logic [3:0]  e_strb;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vq[$];

    task automatic add(input int s, input logic req, input logic wr, input logic [1:0] sz,
                       input logic [3:0] strb, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic ls, input logic aok,
                       input logic dok, input logic [31:0] rdata, input logic es,
                       input logic er, input logic [31:0] erd, input logic bus,
                       input logic ewr, input logic [1:0] esz, input logic [3:0] estrb,
                       input logic [31:0] eaddr, input logic [31:0] ewdata);
        vec_t v;
        v.scen = s;     v.req = req;   v.wr = wr;     v.sz = sz;       v.strb = strb;
        v.addr = addr;  v.wdata = wdata; v.ls = ls;   v.aok = aok;     v.dok = dok;
        v.rdata = rdata; v.e_stall = es; v.e_req = er; v.e_rdata = erd; v.bus = bus;
        v.e_wr = ewr;   v.e_sz = esz;  v.e_strb = estrb; v.e_addr = eaddr;
        v.e_wdata = ewdata;
        vq.push_back(v);
    endtask

    task automatic drive(input logic req, input logic wr, input logic [1:0] sz,
                         input logic [3:0] strb, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic ls, input logic aok,
                         input logic dok, input logic [31:0] rdata);
        mem_req = req;   mem_wr = wr;     mem_size = sz;     mem_wstrb = strb;
        mem_addr = addr; mem_wdata = wdata; longest_stall = ls;
        data_addr_ok = aok; data_data_ok = dok; data_rdata = rdata;
    endtask

    task automatic chk(input string nm, input logic es, input logic er,
                       input logic [31:0] erd, input logic bus, input logic ewr,
                       input logic [1:0] esz, input logic [3:0] estrb,
                       input logic [31:0] eaddr, input logic [31:0] ewdata);
        logic ok;
        ok = (d_stall === es) && (data_req === er) && (mem_rdata === erd);
        if (bus) begin
            ok = ok && (data_wr === ewr) && (data_size === esz) &&
                 (data_wstrb === estrb) && (data_addr === eaddr) &&
                 (data_wdata === ewdata);
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got stall=%b req=%b rdata=%h wr=%b sz=%0d strb=%h addr=%h wdata=%h | want stall=%b req=%b rdata=%h wr=%b sz=%0d strb=%h addr=%h wdata=%h (bus=%b)",
                     nm, d_stall, data_req, mem_rdata, data_wr, data_size, data_wstrb,
                     data_addr, data_wdata, es, er, erd, ewr, esz, estrb, eaddr, ewdata, bus);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // ---- vector table
        // 1: load word 0x1000, addr_ok in request cycle, data_ok on 3rd WAIT_DATA cycle
        add(1, 1,0,2,4'hF,32'h1000,0,        1,1,0,0,            1,1,0,            1,0,2,4'h0,32'h1000,0);
        add(1, 1,0,2,4'hF,32'h1000,0,        1,0,0,0,            1,0,0,            0,0,0,0,0,0);
        add(1, 1,0,2,4'hF,32'h1000,0,        1,0,0,0,            1,0,0,            0,0,0,0,0,0);
        add(1, 1,0,2,4'hF,32'h1000,0,        0,0,1,32'hDEADBEEF, 0,0,32'hDEADBEEF, 0,0,0,0,0,0);
        add(1, 0,0,0,4'h0,0,0,               0,0,0,0,            0,0,32'hDEADBEEF, 0,0,0,0,0,0);
        // 2: store byte 0x2003, addr_ok after 3 waits, M-stage perturbed mid-wait
        add(2, 1,1,0,4'h8,32'h2003,32'hAB000000, 1,0,0,0, 1,1,32'hDEADBEEF, 1,1,0,4'h8,32'h2003,32'hAB000000);
        add(2, 1,1,0,4'h8,32'h2003,32'hAB000000, 1,0,0,0, 1,1,32'hDEADBEEF, 1,1,0,4'h8,32'h2003,32'hAB000000);
        add(2, 1,1,2,4'hF,32'h5555,32'h11111111, 1,0,0,0, 1,1,32'hDEADBEEF, 1,1,0,4'h8,32'h2003,32'hAB000000);
        add(2, 1,1,0,4'h8,32'h2003,32'hAB000000, 1,1,0,0, 1,1,32'hDEADBEEF, 1,1,0,4'h8,32'h2003,32'hAB000000);
        add(2, 1,1,0,4'h8,32'h2003,32'hAB000000, 0,0,1,32'hCAFEF00D, 0,0,32'hCAFEF00D, 0,0,0,0,0,0);
        add(2, 0,0,0,4'h0,0,0,               0,0,0,0,            0,0,32'hCAFEF00D, 0,0,0,0,0,0);
        // 3: load completes under a divider stall -> HOLD for 4 cycles
        add(3, 1,0,2,4'hF,32'h3000,0,        1,1,0,0,            1,1,32'hCAFEF00D, 1,0,2,4'h0,32'h3000,0);
        add(3, 1,0,2,4'hF,32'h3000,0,        1,0,1,32'h12345678, 0,0,32'h12345678, 0,0,0,0,0,0);
        add(3, 1,0,2,4'hF,32'h3000,0,        1,0,0,32'hFFFFFFFF, 0,0,32'h12345678, 0,0,0,0,0,0);
        add(3, 1,0,2,4'hF,32'h3000,0,        1,0,0,32'hFFFFFFFF, 0,0,32'h12345678, 0,0,0,0,0,0);
        add(3, 1,0,2,4'hF,32'h3000,0,        1,0,0,32'hFFFFFFFF, 0,0,32'h12345678, 0,0,0,0,0,0);
        add(3, 1,0,2,4'hF,32'h3000,0,        1,0,0,32'hFFFFFFFF, 0,0,32'h12345678, 0,0,0,0,0,0);
        add(3, 1,0,2,4'hF,32'h3000,0,        0,0,0,32'hFFFFFFFF, 0,0,32'h12345678, 0,0,0,0,0,0);
        add(3, 0,0,0,4'h0,0,0,               0,0,0,0,            0,0,32'h12345678, 0,0,0,0,0,0);
        // 5: back-to-back loads 0x10 / 0x14 on a zero-wait bus
        add(5, 1,0,2,4'hF,32'h10,0,          1,1,0,0,            1,1,32'h12345678, 1,0,2,4'h0,32'h10,0);
        add(5, 1,0,2,4'hF,32'h10,0,          0,0,1,32'hA0A0A0A0, 0,0,32'hA0A0A0A0, 0,0,0,0,0,0);
        add(5, 1,0,2,4'hF,32'h14,0,          1,1,0,0,            1,1,32'hA0A0A0A0, 1,0,2,4'h0,32'h14,0);
        add(5, 1,0,2,4'hF,32'h14,0,          0,0,1,32'hB1B1B1B1, 0,0,32'hB1B1B1B1, 0,0,0,0,0,0);
        // 6: spurious data_ok in IDLE and in WAIT_ADDR is ignored
        add(6, 0,0,0,4'h0,0,0,               0,0,1,32'h99999999, 0,0,32'hB1B1B1B1, 0,0,0,0,0,0);
        add(6, 0,0,0,4'h0,0,0,               0,0,0,0,            0,0,32'hB1B1B1B1, 0,0,0,0,0,0);
        add(6, 1,0,1,4'h3,32'h20,0,          1,0,1,32'h77777777, 1,1,32'hB1B1B1B1, 1,0,1,4'h0,32'h20,0);
        add(6, 1,0,1,4'h3,32'h20,0,          1,0,1,32'h77777777, 1,1,32'hB1B1B1B1, 1,0,1,4'h0,32'h20,0);
        add(6, 1,0,1,4'h3,32'h20,0,          1,1,0,0,            1,1,32'hB1B1B1B1, 1,0,1,4'h0,32'h20,0);
        add(6, 1,0,1,4'h3,32'h20,0,          0,0,1,32'h0000BEEF, 0,0,32'h0000BEEF, 0,0,0,0,0,0);
        add(6, 0,0,0,4'h0,0,0,               0,0,0,0,            0,0,32'h0000BEEF, 0,0,0,0,0,0);

        // ---- reset state, with mem_req high to show request is suppressed
        rst = 1'b0;
        drive(1,1,2,4'hF,32'h1234,32'h5678, 1,1,1,32'h1111);
        #2;
        chk("reset_state", 0,0,0, 1,0,0,4'h0,0,0);
        @(negedge clk);
        drive(0,0,0,4'h0,0,0, 0,0,0,0);
        rst = 1'b1;

        // ---- table
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].req, vq[i].wr, vq[i].sz, vq[i].strb, vq[i].addr, vq[i].wdata,
                  vq[i].ls, vq[i].aok, vq[i].dok, vq[i].rdata);
            #2;
            chk($sformatf("scen%0d_row%0d", vq[i].scen, i), vq[i].e_stall, vq[i].e_req,
                vq[i].e_rdata, vq[i].bus, vq[i].e_wr, vq[i].e_sz, vq[i].e_strb,
                vq[i].e_addr, vq[i].e_wdata);
        end

        // ---- 4: async reset while in WAIT_DATA
        @(negedge clk);
        drive(1,0,2,4'hF,32'h4000,0, 1,1,0,0);
        #2;
        chk("rst_issue", 1,1,32'h0000BEEF, 1,0,2,4'h0,32'h4000,0);
        @(negedge clk);
        drive(1,0,2,4'hF,32'h4000,0, 1,0,0,0);
        #2;
        chk("rst_wait_data", 1,0,32'h0000BEEF, 0,0,0,0,0,0);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_mid_cycle", 0,0,0, 1,0,0,4'h0,0,0);
        @(negedge clk);
        drive(0,0,0,4'h0,0,0, 0,0,0,0);
        rst = 1'b1;
        #2;
        chk("rst_release", 0,0,0, 0,0,0,0,0,0);
        @(negedge clk);
        drive(0,0,0,4'h0,0,0, 0,0,1,32'h55555555);
        #2;
        chk("rst_no_req", 0,0,0, 0,0,0,0,0,0);
        @(negedge clk);
        drive(1,0,2,4'hF,32'h4004,0, 1,1,0,0);
        #2;
        chk("post_rst_issue", 1,1,0, 1,0,2,4'h0,32'h4004,0);
        @(negedge clk);
        drive(1,0,2,4'hF,32'h4004,0, 0,0,1,32'h0BADF00D);
        #2;
        chk("post_rst_data", 0,0,32'h0BADF00D, 0,0,0,0,0,0);
        @(negedge clk);
        drive(0,0,0,4'h0,0,0, 0,0,0,0);
        #2;
        chk("post_rst_idle", 0,0,32'h0BADF00D, 0,0,0,0,0,0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
